// File: rtl/transpose_pkg.sv
// rtl/transpose_pkg.sv - shared helpers for the streaming transpose unit
package transpose_pkg;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// rtl/transpose_bank.sv - one NUM x WIDTH row store with a column read mux
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int WIDTH = 6
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [cnt_w(NUM)-1:0]      i_wrow,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic [cnt_w(WIDTH)-1:0]    i_rcol,
  output logic [NUM-1:0]             o_rdata
);

  logic [WIDTH-1:0] r_mem [NUM];

  // Row write port; the whole array clears on reset so the read mux is deterministic.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM; r++) begin
        r_mem[r] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wrow] <= i_wdata;
    end
  end

  // Column read: bit r of the output is bit i_rcol of stored row r.
  always_comb begin
    o_rdata = '0;
    for (int r = 0; r < NUM; r++) begin
      o_rdata[r] = r_mem[r][i_rcol];
    end
  end

endmodule

// File: rtl/transpose_stream.sv
// rtl/transpose_stream.sv - ping-pong row-in / column-out streaming transpose
module transpose_stream
  import transpose_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int WIDTH = 6
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [NUM-1:0]    out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err_last
);

  localparam int ROW_W = cnt_w(NUM);
  localparam int COL_W = cnt_w(WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  logic [1:0]       r_full;
  logic             r_wsel;
  logic             r_rsel;
  logic [ROW_W-1:0] r_wrow;
  logic [COL_W-1:0] r_rcol;
  logic             r_err_last;

  logic [1:0]       w_full_nxt;
  logic [1:0]       w_we;
  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_row_end;
  logic             w_col_end;
  logic [NUM-1:0]   w_rdata [2];

  assign in_ready  = !r_full[r_wsel];
  assign out_valid = r_full[r_rsel];
  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_row_end = (r_wrow == ROW_LAST);
  assign w_col_end = (r_rcol == COL_LAST);
  assign w_we[0]   = w_wr_fire && !r_wsel;
  assign w_we[1]   = w_wr_fire && r_wsel;
  assign out_data  = w_rdata[r_rsel];
  assign out_last  = out_valid && w_col_end;
  assign err_last  = r_err_last;

  transpose_bank #(.NUM(NUM), .WIDTH(WIDTH)) u_bank0 (
    .clock   (clock),
    .rst     (rst),
    .i_we    (w_we[0]),
    .i_wrow  (r_wrow),
    .i_wdata (in_data),
    .i_rcol  (r_rcol),
    .o_rdata (w_rdata[0])
  );

  transpose_bank #(.NUM(NUM), .WIDTH(WIDTH)) u_bank1 (
    .clock   (clock),
    .rst     (rst),
    .i_we    (w_we[1]),
    .i_wrow  (r_wrow),
    .i_wdata (in_data),
    .i_rcol  (r_rcol),
    .o_rdata (w_rdata[1])
  );

  // Fill and drain always target different banks, so both updates apply together.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_fire && w_row_end) begin
      w_full_nxt[r_wsel] = 1'b1;
    end
    if (w_rd_fire && w_col_end) begin
      w_full_nxt[r_rsel] = 1'b0;
    end
  end

  // Bank occupancy flags.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // Write side: row counter and bank select; a block ends purely on row count.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wrow <= '0;
      r_wsel <= 1'b0;
    end else if (w_wr_fire) begin
      if (w_row_end) begin
        r_wrow <= '0;
        r_wsel <= !r_wsel;
      end else begin
        r_wrow <= r_wrow + 1'b1;
      end
    end
  end

  // Read side: column counter and bank select.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_rcol <= '0;
      r_rsel <= 1'b0;
    end else if (w_rd_fire) begin
      if (w_col_end) begin
        r_rcol <= '0;
        r_rsel <= !r_rsel;
      end else begin
        r_rcol <= r_rcol + 1'b1;
      end
    end
  end

  // Sticky flag for an in_last marker that disagrees with the row position.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_err_last <= 1'b0;
    end else if (w_wr_fire && (in_last != w_row_end)) begin
      r_err_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_transpose_stream.sv
// tb/tb_transpose_stream.sv - scoreboard bench for transpose_stream
module tb_transpose_stream;

  localparam int NUM   = 8;
  localparam int WIDTH = 6;

  logic             clock = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [NUM-1:0]   out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             err_last;

  always #5 clock = ~clock;

  transpose_stream #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err_last  (err_last)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [NUM:0]     exp_q [$];
  logic [WIDTH-1:0] blk_rows [$];
  bit   use_model = 1'b1;
  bit   rand_en = 1'b0;
  bit   ready_req = 1'b0;
  bit   strict_ready = 1'b0;
  int   stall_cnt = 0;
  int   popped = 0;
  int   p0 = 0;
  logic acc_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect NUM rows, then column c is the bit-c slice across rows.
  function automatic void model_accept(input logic [WIDTH-1:0] row);
    if (!use_model) return;
    blk_rows.push_back(row);
    if (blk_rows.size() == NUM) begin
      for (int c = 0; c < WIDTH; c++) begin
        logic [NUM-1:0] col;
        for (int r = 0; r < NUM; r++) begin
          col[r] = blk_rows[r][c];
        end
        exp_q.push_back({(c == WIDTH - 1), col});
      end
      blk_rows.delete();
    end
  endfunction

  task automatic send_row(input logic [WIDTH-1:0] d, input logic last);
    bit acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < 5000 && !acc; i++) begin
      @(negedge clock);
      acc    = in_ready;
      acc_ov = out_valid;
      if (strict_ready && !in_ready) stall_cnt++;
      @(posedge clock);
      #1;
    end
    if (acc) model_accept(d);
    else chk("row_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_ready(input bit v);
    ready_req = v;
    idle(2);
  endtask

  task automatic wait_drain();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    idle(2);
    chk("drain_queue_empty", exp_q.size(), 32'd0);
    @(negedge clock);
    chk("drain_out_valid_low", out_valid, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    blk_rows.delete();
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  task automatic monitor();
    logic [NUM-1:0] prev_d;
    bit             prev_stall;
    logic [NUM:0]   e;
    prev_d = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clock);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) chk("out_data_stable", out_data, prev_d);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_column", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            popped++;
            chk("col_data", out_data, e[NUM-1:0]);
            chk("col_last", out_last, e[NUM]);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clock);
      #1;
      out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_req;
    end
  endtask

  initial begin
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    fork
      monitor();
      ready_drv();
      begin
        #800000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    chk("reset_out_valid", out_valid, 32'd0);
    chk("reset_out_last", out_last, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_err_last", err_last, 32'd0);
    chk("reset_in_ready", in_ready, 32'd1);
    @(posedge clock);
    #1;

    // Identity block with directed expectations.
    set_ready(1'b1);
    use_model = 1'b0;
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hCC});
    exp_q.push_back({1'b0, 8'hF0});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    for (int r = 0; r < NUM; r++) send_row(WIDTH'(r), r == NUM - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_valid_before_last_row", acc_ov, 32'd0);
    @(negedge clock);
    chk("latency_valid_after_last_row", out_valid, 32'd1);
    @(posedge clock);
    #1;
    wait_drain();
    use_model = 1'b1;
    chk("identity_err_last", err_last, 32'd0);

    // Four back-to-back blocks at full rate.
    strict_ready = 1'b1;
    stall_cnt = 0;
    p0 = popped;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < NUM; r++) send_row(WIDTH'($urandom), r == NUM - 1);
    strict_ready = 1'b0;
    wait_drain();
    chk("stream_in_ready_stalls", stall_cnt, 32'd0);
    chk("stream_columns", popped - p0, 32'd24);

    // Backpressure: two full banks stop the producer.
    set_ready(1'b0);
    for (int r = 0; r < 2 * NUM; r++)
      send_row((r < NUM) ? WIDTH'(r) : WIDTH'($urandom), (r % NUM) == NUM - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clock);
    chk("bp_in_ready_low", in_ready, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", out_valid, 32'd1);
      chk("bp_hold_data", out_data, 32'hAA);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    p0 = popped;
    set_ready(1'b1);
    wait_drain();
    chk("bp_columns", popped - p0, 32'd12);

    // in_last on the wrong row.
    for (int r = 0; r < NUM; r++) begin
      send_row(WIDTH'($urandom), r == 3);
      if (r == 3) begin
        in_valid = 1'b0;
        @(negedge clock);
        chk("err_last_set", err_last, 32'd1);
        @(posedge clock);
        #1;
      end
    end
    wait_drain();
    chk("err_last_sticky", err_last, 32'd1);

    // Reset with a full bank and a partial block queued.
    set_ready(1'b0);
    for (int r = 0; r < NUM + 5; r++) send_row(WIDTH'($urandom), (r % NUM) == NUM - 1);
    do_reset();
    @(negedge clock);
    chk("mid_reset_out_valid", out_valid, 32'd0);
    chk("mid_reset_in_ready", in_ready, 32'd1);
    chk("mid_reset_err_last", err_last, 32'd0);
    @(posedge clock);
    #1;
    set_ready(1'b1);
    @(negedge clock);
    chk("post_reset_no_output", out_valid, 32'd0);
    @(posedge clock);
    #1;
    use_model = 1'b0;
    for (int c = 0; c < WIDTH; c++) exp_q.push_back({(c == WIDTH - 1), 8'hFF});
    for (int r = 0; r < NUM; r++) send_row(6'h3F, r == NUM - 1);
    wait_drain();
    use_model = 1'b1;

    // Random stalls on both sides.
    rand_en = 1'b1;
    p0 = popped;
    for (int b = 0; b < 1000; b++)
      for (int r = 0; r < NUM; r++) begin
        idle(int'($urandom_range(0, 2)));
        send_row(WIDTH'($urandom), r == NUM - 1);
      end
    wait_drain();
    rand_en = 1'b0;
    chk("random_columns", popped - p0, 32'd6000);
    chk("random_err_last", err_last, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
